serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes diff = a - b one bit per clock, LSB first, using a single registered borrow.
- It is the inverse-direction companion to the team's full-adder cell and reuses the same sum/borrow equations.
- Sits in the datapath wherever area matters more than latency: one start pulse in, one done pulse out.

Parameters:
- NUM_BITS, 8, operand and result width; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  NUM_BITS  minuend, unsigned (two's complement when the optional feature is on); captured on the accepted start edge.
- b  input  NUM_BITS  subtrahend; captured on the accepted start edge.
- busy  output  1  high while state == RUN.
- done  output  1  single-cycle pulse; result valid.
- diff  output  NUM_BITS  a - b modulo 2^NUM_BITS; registered.
- borrow_out  output  1  high when unsigned a < b; registered.
- overflow  output  1  signed overflow flag (see Optional Feature); registered.

Behaviour:
- Clocking and reset: one clock (clk). Reset rst is asynchronous, active-high.
- Reset values: state = IDLE, busy = 0, done = 0, diff = 0, borrow_out = 0, overflow = 0, internal shift registers, borrow flop and bit counter all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start = 1 at a rising edge: load a_sr = a, b_sr = b, borrow = 0, cnt = 0; go to RUN.
  - When start = 0: stay in IDLE.
- RUN, on each edge:
  - a0 = a_sr[0], b0 = b_sr[0].
  - d = a0 ^ b0 ^ borrow.
  - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - d shifts into the MSB of res_sr (right shift); a_sr and b_sr shift right; cnt increments.
- RUN exit: on the edge where cnt reaches NUM_BITS-1 (the last bit), go to DONE and load the outputs in the same edge:
  - diff = final res_sr including that bit.
  - borrow_out = borrow_next.
  - overflow per the Optional Feature.
- DONE: done = 1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Start accepted at edge 0.
  - busy is high from edge 0 to edge NUM_BITS.
  - done is high between edge NUM_BITS and edge NUM_BITS+1, i.e. the result appears NUM_BITS cycles after the start edge.
- Throughput: one operation per NUM_BITS+2 cycles. A start held continuously begins the next operation on the edge after DONE.
- start while in RUN or DONE is ignored. There is no queuing, and operands captured for the current operation are unaffected.
- a and b may change freely after the accepted start edge.
- diff, borrow_out and overflow hold their values until the next DONE. They are not cleared on a new start.
- Reset asserted mid-operation: all state returns to reset values immediately. No done pulse is produced, and the partial result is discarded.
- Counter width is $clog2(NUM_BITS).
- Arithmetic is modulo 2^NUM_BITS. borrow_out equals the inverse of the carry of a + ~b + 1.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- When defined:
  - During the last RUN bit, record a_msb = a0 and b_msb = b0.
  - overflow = (a_msb ^ b_msb) & (d ^ a_msb), loaded with diff at DONE entry; this is two's-complement overflow of a - b.
- When not defined:
  - overflow is tied to 0.
  - No extra flops are inferred.
  - The port remains so the interface is identical.

Test Plan:
- NUM_BITS = 8, a = 100, b = 37, start pulse for 1 cycle -> busy high for 8 cycles; done pulse on cycle 8; diff = 63, borrow_out = 0, overflow = 0.
- a = 5, b = 10 -> diff = 251 (0xFB), borrow_out = 1; a = 0, b = 0 -> diff = 0, borrow_out = 0; a = 255, b = 0 -> diff = 255, borrow_out = 0.
- With SERIAL_SUB_SIGNED_OVF_EN defined: a = 0x80, b = 0x01 -> diff = 0x7F, overflow = 1; a = 0x7F, b = 0xFF -> diff = 0x80, overflow = 1. Without the macro, overflow = 0 in both cases.
- Start accepted with a = 50, b = 20; pulse start again with a = 1, b = 1 on cycle 3 -> second start ignored; diff = 30 with a single done pulse.
- Start with a = 200, b = 100; assert rst asynchronously mid-cycle at cycle 4 -> all outputs 0 immediately; no done pulse. After release, a new start with a = 9, b = 4 -> diff = 5.
- start held high continuously with fixed a = 7, b = 3 -> done pulses every 10 cycles; diff stays 4.

Source files
------------

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial NUM_BITS-wide subtractor: diff = a - b, one bit per clock, LSB
// first, using a single registered borrow. A start pulse in IDLE captures the
// operands. NUM_BITS RUN cycles follow, then a one-cycle DONE pulse presents
// the registered result.
//
// Parameters:
//   NUM_BITS    operand/result width, legal range 2..32
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       request; sampled only while IDLE
//   a, b        minuend / subtrahend, captured on the accepted start edge
//   busy        high while the FSM is in RUN
//   done        one-cycle pulse; diff/borrow_out/overflow are valid
//   diff        a - b modulo 2^NUM_BITS (held until the next DONE)
//   borrow_out  1 when unsigned a < b (held until the next DONE)
//   overflow    two's-complement overflow of a - b (held until the next DONE)
//
// Optional build macro:
//   SERIAL_SUB_SIGNED_OVF_EN  when defined, overflow reports signed overflow;
//                             otherwise it is tied to 0 and has no flop.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                borrow_out,
    output logic                overflow
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [NUM_BITS-1:0]   a_sr_q,       a_sr_d;
    logic [NUM_BITS-1:0]   b_sr_q,       b_sr_d;
    // Only NUM_BITS-1 result bits need storing: the final bit goes straight
    // into diff on the last RUN edge together with these.
    logic [NUM_BITS-2:0]   res_sr_q,     res_sr_d;
    logic                  borrow_q,     borrow_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [NUM_BITS-1:0]   diff_q,       diff_d;
    logic                  borrow_out_q, borrow_out_d;

    logic                  a0;
    logic                  b0;
    logic                  d_bit;
    logic                  borrow_nxt;
    logic [NUM_BITS-1:0]   res_shifted;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic                  ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs
    assign a0          = a_sr_q[0];
    assign b0          = b_sr_q[0];
    assign d_bit       = a0 ^ b0 ^ borrow_q;
    assign borrow_nxt  = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
    assign res_shifted = {d_bit, res_sr_q};

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_sr_d     = res_sr_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ovf_d        = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shifted[NUM_BITS-1:1];
                borrow_d = borrow_nxt;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d      = S_DONE;
                    diff_d       = res_shifted;
                    borrow_out_d = borrow_nxt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    // a0/b0 are the operand sign bits on this last bit
                    ovf_d        = (a0 ^ b0) & (d_bit ^ a0);
`endif
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_sr_q     <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_sr_q     <= res_sr_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
        end
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

endmodule
